ex_mem_stage: RTL

- Pipeline register and branch-resolution stage directly downstream of the 32-bit ALU.
- Captures ALU result and flags (Z, V, C, S) with forwarded EX-stage context: PC, immediate, rs2 data, rd, control.
- Resolves conditional branches and jumps from the flags, then presents registered results to the memory stage.
- Supports stall, flush and a valid bit so it fits a 5-stage pipeline.

---
 rtl/ex_mem_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// EX/MEM pipeline register with branch/jump resolution. Sits directly after
// the 32-bit ALU, captures the ALU result and flags together with the
// forwarded EX context, resolves conditional branches and jumps, and presents
// registered results plus a redirect request to the memory stage.
//
// Flow control: in_valid qualifies every EX-stage input on the cycle it is
// presented. There is no ready output; stall is the only backpressure. With
// stall=1 nothing is captured and every output holds, including a pending
// redirect, so upstream must stall coherently. flush squashes the instruction
// being captured. Edge priority is rst > flush > stall > capture.
//
// Optional build macro: BRANCH_STATS_EN adds stat_branches / stat_taken.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   stall, flush              hold outputs / squash the captured instruction
//   in_valid                  EX instruction valid
//   alu_result, alu_z/v/c/s   ALU output and flags (C = carry of A + ~B + 1)
//   pc, imm, rs2_data         EX PC, sign-extended immediate, store data
//   rd_addr, funct3           destination register, branch/memory funct3
//   is_branch, is_jal, is_jalr, mem_read, mem_write, reg_write, mem_to_reg
//                             decoded control
//   out_valid                 registered valid
//   out_result                ALU result, or PC+4 for JAL/JALR
//   out_store_data, out_rd, out_funct3
//                             registered forwarded context
//   out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg
//                             registered control, gated by valid
//   redirect, redirect_pc     taken branch or jump, and its target
//   stat_branches, stat_taken (BRANCH_STATS_EN only) branch counters
// ---------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int N    = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [N-1:0]    alu_result,
   input  logic            alu_z,
   input  logic            alu_v,
   input  logic            alu_c,
   input  logic            alu_s,
   input  logic [N-1:0]    pc,
   input  logic [N-1:0]    imm,
   input  logic [N-1:0]    rs2_data,
   input  logic [RD_W-1:0] rd_addr,
   input  logic [2:0]      funct3,
   input  logic            is_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            reg_write,
   input  logic            mem_to_reg,
   output logic            out_valid,
   output logic [N-1:0]    out_result,
   output logic [N-1:0]    out_store_data,
   output logic [RD_W-1:0] out_rd,
   output logic [2:0]      out_funct3,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_reg_write,
   output logic            out_mem_to_reg,
   output logic            redirect,
   output logic [N-1:0]    redirect_pc
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_taken
`endif
);

   localparam logic [N-1:0] FOUR = N'(4);

   logic         cond_true;
   logic         br_taken;
   logic         is_jump;
   logic         nxt_redirect;
   logic [N-1:0] pc_plus4;
   logic [N-1:0] pc_plus_imm;
   logic [N-1:0] nxt_redirect_pc;
   logic [N-1:0] nxt_result;

   // Branch condition from the ALU flags of rs1 - rs2.
   always_comb begin
      cond_true = 1'b0;
      case (funct3)
         3'b000:  cond_true = alu_z;              // BEQ
         3'b001:  cond_true = ~alu_z;             // BNE
         3'b100:  cond_true = alu_s ^ alu_v;      // BLT
         3'b101:  cond_true = ~(alu_s ^ alu_v);   // BGE
         3'b110:  cond_true = ~alu_c;             // BLTU: borrow means rs1 < rs2
         3'b111:  cond_true = alu_c;              // BGEU
         default: cond_true = 1'b0;               // 010/011 never taken
      endcase
   end

   always_comb begin
      br_taken     = is_branch & cond_true;
      is_jump      = is_jal | is_jalr;
      nxt_redirect = in_valid & (br_taken | is_jump);
      pc_plus4     = pc + FOUR;
      pc_plus_imm  = pc + imm;

      // A jump wins over a simultaneously decoded branch: with is_jal/is_jalr
      // set the target never depends on br_taken.
      nxt_redirect_pc = pc_plus4;
      if (nxt_redirect) begin
         if (is_jalr) begin
            nxt_redirect_pc = {alu_result[N-1:1], 1'b0};
         end else begin
            nxt_redirect_pc = pc_plus_imm;
         end
      end

      nxt_result = is_jump ? pc_plus4 : alu_result;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_store_data <= '0;
         out_rd         <= '0;
         out_funct3     <= '0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
         out_reg_write  <= 1'b0;
         out_mem_to_reg <= 1'b0;
         redirect       <= 1'b0;
         redirect_pc    <= '0;
`ifdef BRANCH_STATS_EN
         stat_branches  <= '0;
         stat_taken     <= '0;
`endif
      end else if (flush) begin
         // Squash: valid, redirect and side-effecting control drop. The data
         // registers still load; their contents are meaningless downstream.
         out_valid      <= 1'b0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
         out_reg_write  <= 1'b0;
         out_mem_to_reg <= 1'b0;
         redirect       <= 1'b0;
         out_result     <= nxt_result;
         out_store_data <= rs2_data;
         out_rd         <= rd_addr;
         out_funct3     <= funct3;
         redirect_pc    <= nxt_redirect_pc;
      end else if (!stall) begin
         out_valid      <= in_valid;
         out_result     <= nxt_result;
         out_store_data <= rs2_data;
         out_rd         <= rd_addr;
         out_funct3     <= funct3;
         out_mem_read   <= mem_read & in_valid;
         out_mem_write  <= mem_write & in_valid;
         out_reg_write  <= reg_write & in_valid;
         out_mem_to_reg <= mem_to_reg & in_valid;
         redirect       <= nxt_redirect;
         redirect_pc    <= nxt_redirect_pc;
`ifdef BRANCH_STATS_EN
         if (in_valid && is_branch) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (in_valid && br_taken) begin
            stat_taken <= stat_taken + 32'd1;
         end
`endif
      end
   end

endmodule
